// File: rtl/dac_writer.sv
// Serializes {2'b00, pd, data} as a 16-bit SYNC-framed word, MSB first, on registered sync/sclk/sdin.
// Latency: a write accepted while idle drives sync low on the next cycle; a frame lasts 32*HALF_PERIOD cycles.
// Backpressure: none; one pending entry is held while busy, and a second write overwrites it and flags overrun.
module dac_writer #(
  parameter int HALF_PERIOD = 10,
  parameter int GAP_HALVES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [11:0] data,
  input  logic [1:0]  pd,
  input  logic        overrun_clr,
  output logic        sync,
  output logic        sclk,
  output logic        sdin,
  output logic        busy,
  output logic        write_done,
  output logic        overrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam int BIT_LEN = 2 * HALF_PERIOD;
  localparam int GAP_LEN = GAP_HALVES * HALF_PERIOD;
  localparam int MAX_LEN = (BIT_LEN > GAP_LEN) ? BIT_LEN : GAP_LEN;
  localparam int CW      = $clog2(MAX_LEN);

  localparam logic [CW-1:0] HALF_END = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(BIT_LEN - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_LEN - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;        // cycle position within the current bit or gap
  logic [3:0]    bit_idx;    // index of the bit currently on sdin
  logic [15:0]   frame;
  logic [13:0]   pend_word;
  logic          pend_valid;

  logic [15:0] in_frame;
  logic [15:0] pend_frame;
  logic [3:0]  next_idx;
  logic        gap_done;
  logic        launch_pend;
  logic        queue_write;

  assign in_frame    = {2'b00, pd, data};
  assign pend_frame  = {2'b00, pend_word};
  assign next_idx    = bit_idx - 4'd1;
  assign busy        = (state != ST_IDLE);
  assign gap_done    = (state == ST_GAP) && (cnt == GAP_END);
  assign launch_pend = gap_done && pend_valid;
  assign queue_write = busy && write;

  // Frame sequencer: drives sync/sclk/sdin and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= 4'd0;
      frame      <= 16'd0;
      sync       <= 1'b1;
      sclk       <= 1'b1;
      sdin       <= 1'b0;
      write_done <= 1'b0;
    end else begin
      write_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (write) begin
            frame   <= in_frame;
            state   <= ST_SHIFT;
            cnt     <= '0;
            bit_idx <= 4'd15;
            sync    <= 1'b0;
            sclk    <= 1'b1;
            sdin    <= in_frame[15];
          end
        end
        ST_SHIFT: begin
          if (cnt == BIT_END) begin
            // sclk rises here; next bit goes out on the same edge
            cnt  <= '0;
            sclk <= 1'b1;
            if (bit_idx == 4'd0) begin
              state <= ST_GAP;
              sync  <= 1'b1;
              sdin  <= 1'b0;
            end else begin
              bit_idx <= next_idx;
              sdin    <= frame[next_idx];
            end
          end else begin
            if (cnt == HALF_END) begin
              sclk <= 1'b0;
            end
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_END) begin
            write_done <= 1'b1;
            cnt        <= '0;
            if (pend_valid) begin
              frame   <= pend_frame;
              state   <= ST_SHIFT;
              bit_idx <= 4'd15;
              sync    <= 1'b0;
              sclk    <= 1'b1;
              sdin    <= pend_frame[15];
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          sync  <= 1'b1;
          sclk  <= 1'b1;
          sdin  <= 1'b0;
        end
      endcase
    end
  end

  // One-entry holding register for writes that arrive while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_word  <= 14'd0;
      pend_valid <= 1'b0;
    end else if (queue_write) begin
      pend_word  <= {pd, data};
      pend_valid <= 1'b1;
    end else if (launch_pend) begin
      pend_valid <= 1'b0;
    end
  end

  // Sticky overrun: an unlaunched pending entry was replaced; set beats clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (queue_write && pend_valid && !launch_pend) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule
